// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet receive framer.
//   state_t      framer FSM state encoding
//   byte values  preamble and start-of-frame delimiter
//   CRC values   CRC-32 seed, generator polynomial and good-frame residue
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2,
        DISCARD  = 2'd3
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
    // Register value after a frame plus its own correct FCS has been absorbed.
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;

endpackage

// File: rtl/rgmii_rx_framer_if.sv
// Receive stream bundle between the nibble demux, the framer and its consumer.
//   in_valid / in_dv / in_er / in_data   demuxed PHY receive signals
//   out_valid / out_data / out_sof / out_eof / out_crc_ok / out_err   framed payload
// Handshake: in_valid qualifies every in_* signal on the cycle it is high; there is
// no back-pressure on either side. out_valid is a single-cycle strobe and the
// consumer must take out_data on every cycle it is high; out_sof/out_eof/out_crc_ok/
// out_err are meaningful only while out_valid is high.
// modport slave  : the framer (consumes in_*, produces out_*)
// modport master : the upstream/downstream environment
interface rgmii_rx_framer_if;

    logic       in_valid;
    logic       in_dv;
    logic       in_er;
    logic [7:0] in_data;

    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sof;
    logic       out_eof;
    logic       out_crc_ok;
    logic       out_err;

    modport master (
        output in_valid, in_dv, in_er, in_data,
        input  out_valid, out_data, out_sof, out_eof, out_crc_ok, out_err
    );

    modport slave (
        input  in_valid, in_dv, in_er, in_data,
        output out_valid, out_data, out_sof, out_eof, out_crc_ok, out_err
    );

endinterface

// File: rtl/rgmii_rx_framer_crc32_d8.sv
// Combinational CRC-32 next-state for one byte.
//   crc_in   current CRC register
//   data     received byte; bit 0 is the first bit on the wire
//   crc_out  register value after absorbing the byte
// The register is kept in MSB-first form while data bits are consumed LSB first,
// which is the bit-reversed view of the reflected CRC; the good-frame residue in
// this form is CRC_RESIDUE.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[31] ^ data[i]) begin
                c = {c[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/rgmii_rx_framer.sv
// Ethernet receive framer for the PHY rx clock domain.
// Assembles bytes from a nibble (10/100) or byte (1000) stream, strips preamble
// and SFD, streams the frame (DA .. FCS) with SOF/EOF, checks the FCS, enforces
// length limits and counts good and bad frames.
//   clock, reset   PHY rx clock, synchronous active-high reset
//   speed_1Gbit    1 = byte stream, 0 = nibble stream; taken only while idle
//   rx             stream bundle (slave side)
//   active         high from SFD acceptance until the EOF beat
//   frame_cnt      frames ending with good FCS and no error (wraps)
//   err_cnt        frames ending with bad FCS or an error (wraps)
//   fsm_state      current framer state, for observation
module rgmii_rx_framer
    import eth_pkg::*;
#(
    parameter int MIN_PREAMBLE = 5,
    parameter int MIN_LEN      = 64,
    parameter int MAX_LEN      = 1522,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             speed_1Gbit,
    rgmii_rx_framer_if.slave rx,
    output logic             active,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output state_t           fsm_state
);

    // Wide enough to hold the saturated value MAX_LEN+1.
    localparam int               LEN_W   = $clog2(MAX_LEN + 2);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);
    localparam logic [2:0]       PRE_MIN = 3'(MIN_PREAMBLE);

    state_t           state;
    logic             mode_1g;      // speed latched while idle
    logic             dv_q;         // in_dv on the last qualified cycle
    logic             nib_phase;    // 1 = low nibble captured, waiting for high
    logic [3:0]       nib_lo;
    logic [2:0]       pre_cnt;
    logic [7:0]       hold;
    logic             hold_valid;
    logic             first_beat;   // next emitted byte is the SOF
    logic             err_sticky;
    logic [LEN_W-1:0] len;
    logic [31:0]      crc;

    logic             byte_mode;
    logic             dv_on;
    logic             dv_rise;
    logic             dv_fall;
    logic             byte_done;
    logic [7:0]       byte_val;
    logic [2:0]       pre_base;
    logic [2:0]       pre_next;
    logic             sfd_hit;
    logic             eof_crc_ok;
    logic             eof_err;
    logic [31:0]      crc_next;

    crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (byte_val),
        .crc_out (crc_next)
    );

    assign fsm_state = state;

    always_comb begin
        // While idle the live speed input decides how the first beat is assembled.
        byte_mode  = (state == IDLE) ? speed_1Gbit : mode_1g;
        dv_on      = rx.in_valid & rx.in_dv;
        dv_rise    = dv_on & ~dv_q;
        dv_fall    = rx.in_valid & ~rx.in_dv & dv_q;
        byte_done  = dv_on & (byte_mode | nib_phase);
        byte_val   = byte_mode ? rx.in_data : {rx.in_data[3:0], nib_lo};
        // A byte completing on the dv rising edge starts a fresh preamble count.
        pre_base   = (state == PREAMBLE) ? pre_cnt : 3'd0;
        sfd_hit    = byte_done && (byte_val == SFD_BYTE) && (pre_base >= PRE_MIN);
        if (byte_val == PREAMBLE_BYTE) begin
            pre_next = (pre_base == 3'd7) ? 3'd7 : pre_base + 3'd1;
        end else begin
            pre_next = 3'd0;
        end
        eof_crc_ok = (crc == CRC_RESIDUE);
        // A dangling nibble at dv fall means the frame was not byte aligned.
        eof_err    = err_sticky | (len < LEN_MIN) | (~mode_1g & nib_phase);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            mode_1g       <= 1'b0;
            dv_q          <= 1'b0;
            nib_phase     <= 1'b0;
            nib_lo        <= 4'd0;
            pre_cnt       <= 3'd0;
            hold          <= 8'd0;
            hold_valid    <= 1'b0;
            first_beat    <= 1'b0;
            err_sticky    <= 1'b0;
            len           <= '0;
            crc           <= CRC_INIT;
            active        <= 1'b0;
            frame_cnt     <= '0;
            err_cnt       <= '0;
            rx.out_valid  <= 1'b0;
            rx.out_data   <= 8'd0;
            rx.out_sof    <= 1'b0;
            rx.out_eof    <= 1'b0;
            rx.out_crc_ok <= 1'b0;
            rx.out_err    <= 1'b0;
        end else begin
            rx.out_valid  <= 1'b0;
            rx.out_sof    <= 1'b0;
            rx.out_eof    <= 1'b0;
            rx.out_crc_ok <= 1'b0;
            rx.out_err    <= 1'b0;

            if (rx.in_valid) begin
                dv_q <= rx.in_dv;
            end
            if (state == IDLE) begin
                mode_1g <= speed_1Gbit;
            end

            // Nibble assembly; in_dv is only meaningful on qualified cycles.
            if (rx.in_valid & ~rx.in_dv) begin
                nib_phase <= 1'b0;
            end else if (dv_on & ~byte_mode) begin
                if (!nib_phase) begin
                    nib_lo <= rx.in_data[3:0];
                end
                nib_phase <= ~nib_phase;
            end

            case (state)
                IDLE: begin
                    if (dv_rise) begin
                        if (sfd_hit) begin
                            state      <= PAYLOAD;
                            crc        <= CRC_INIT;
                            len        <= '0;
                            hold_valid <= 1'b0;
                            first_beat <= 1'b1;
                            err_sticky <= 1'b0;
                            active     <= 1'b1;
                        end else begin
                            state   <= PREAMBLE;
                            pre_cnt <= byte_done ? pre_next : 3'd0;
                        end
                    end
                end

                PREAMBLE: begin
                    if (dv_fall) begin
                        state   <= IDLE;
                        pre_cnt <= 3'd0;
                    end else if (sfd_hit) begin
                        state      <= PAYLOAD;
                        crc        <= CRC_INIT;
                        len        <= '0;
                        hold_valid <= 1'b0;
                        first_beat <= 1'b1;
                        err_sticky <= 1'b0;
                        active     <= 1'b1;
                    end else if (byte_done) begin
                        pre_cnt <= pre_next;
                    end
                end

                PAYLOAD: begin
                    if (dv_fall) begin
                        state      <= IDLE;
                        active     <= 1'b0;
                        hold_valid <= 1'b0;
                        if (hold_valid) begin
                            rx.out_valid  <= 1'b1;
                            rx.out_data   <= hold;
                            rx.out_sof    <= first_beat;
                            rx.out_eof    <= 1'b1;
                            rx.out_crc_ok <= eof_crc_ok;
                            rx.out_err    <= eof_err;
                            if (eof_crc_ok & ~eof_err) begin
                                frame_cnt <= frame_cnt + CNT_W'(1);
                            end else begin
                                err_cnt <= err_cnt + CNT_W'(1);
                            end
                        end else begin
                            // SFD followed directly by dv fall: nothing to emit.
                            err_cnt <= err_cnt + CNT_W'(1);
                        end
                    end else begin
                        if (dv_on & rx.in_er) begin
                            err_sticky <= 1'b1;
                        end
                        if (byte_done) begin
                            if (len == LEN_MAX) begin
                                // Oversized: close the frame on the held byte and drop the rest.
                                state         <= DISCARD;
                                active        <= 1'b0;
                                hold_valid    <= 1'b0;
                                len           <= LEN_MAX + LEN_W'(1);
                                rx.out_valid  <= hold_valid;
                                rx.out_data   <= hold;
                                rx.out_sof    <= first_beat;
                                rx.out_eof    <= 1'b1;
                                rx.out_crc_ok <= eof_crc_ok;
                                rx.out_err    <= 1'b1;
                                err_cnt       <= err_cnt + CNT_W'(1);
                            end else begin
                                len        <= len + LEN_W'(1);
                                crc        <= crc_next;
                                hold       <= byte_val;
                                hold_valid <= 1'b1;
                                if (hold_valid) begin
                                    rx.out_valid <= 1'b1;
                                    rx.out_data  <= hold;
                                    rx.out_sof   <= first_beat;
                                    first_beat   <= 1'b0;
                                end
                            end
                        end
                    end
                end

                DISCARD: begin
                    if (dv_fall) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
